// File: rtl/vga_pkg.sv
// Shared VGA timing types and default 640x480@60 constants.
package vga_pkg;

  localparam int CNT_W = 12;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_e;

  // Which interval a count falls in, given the lengths of the first three intervals.
  function automatic phase_e phase_of(input logic [CNT_W-1:0] c, input int a,
                                      input int f, input int s);
    int cv;
    cv = int'(c);
    if (cv < a)              return ACTIVE;
    else if (cv < a + f)     return FRONT;
    else if (cv < a + f + s) return SYNC;
    else                     return BACK;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with registered sync and look-ahead phase.
import vga_pkg::*;

module vga_axis_counter #(
  parameter int ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int FRONT_LEN  = DEF_H_FRONT,
  parameter int SYNC_LEN   = DEF_H_SYNC,
  parameter int BACK_LEN   = DEF_H_BACK,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output phase_e           phase,
  output logic             wrap,
  output logic             sync
);

  localparam int TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  if (ACTIVE_LEN < 1 || FRONT_LEN < 1 || SYNC_LEN < 1 || BACK_LEN < 1 || TOTAL > 4096)
  begin : g_bad_timing
    $fatal(1, "vga_axis_counter: illegal interval lengths");
  end

  logic [CNT_W-1:0] count_nxt;
  phase_e           phase_q;

  // wrap means the next enable returns the count to 0; phase is the phase being entered.
  always_comb begin
    wrap      = (count == LAST);
    count_nxt = wrap ? '0 : count + CNT_W'(1);
    phase     = en ? phase_of(count_nxt, ACTIVE_LEN, FRONT_LEN, SYNC_LEN) : phase_q;
  end

  // Reset parks on the final count so the first enable enters count 0.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count   <= LAST;
      phase_q <= BACK;
      sync    <= ~SYNC_POL;
    end else if (en) begin
      count   <= count_nxt;
      phase_q <= phase;
      sync    <= (phase == SYNC) ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, syncs, display enable and line/frame strobes.
import vga_pkg::*;

module vga_timing_gen #(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
);

  phase_e h_phase;
  phase_e v_phase;
  logic   h_wrap;
  logic   v_wrap;
  logic   v_en;

  assign v_en = pix_ce & h_wrap;

  vga_axis_counter #(
    .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK),
    .SYNC_POL(HSYNC_POL)
  ) u_h (
    .clk_in(clk_in), .rst_n(rst_n), .en(pix_ce),
    .count(x), .phase(h_phase), .wrap(h_wrap), .sync(hsync)
  );

  vga_axis_counter #(
    .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK),
    .SYNC_POL(VSYNC_POL)
  ) u_v (
    .clk_in(clk_in), .rst_n(rst_n), .en(v_en),
    .count(y), .phase(v_phase), .wrap(v_wrap), .sync(vsync)
  );

  // Strobes are recomputed every clock so they drop after one cycle even with pix_ce low.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_ce & h_wrap;
      frame_start <= pix_ce & h_wrap & v_wrap;
      if (pix_ce)
        active <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
    end
  end

endmodule
